// File: rtl/kdf_sched_pkg.sv
// kdf_sched_pkg: shared state encoding and default datapath widths for the
// KDF scheduler and the KDF_spongent instance it feeds.
package kdf_sched_pkg;

    localparam int KDF_N           = 128;
    localparam int KDF_SALT_WIDTH  = 64;
    localparam int KDF_PSW_WIDTH   = 32;
    localparam int KDF_COUNT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ERR
    } kdf_sched_state_t;

endpackage

// File: rtl/kdf_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Returns the first set request
// at or after ptr (wrapping), as a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0] cand;
    logic           found;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise paths
        // with no hit would hold the old value and infer a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IDX_W-1:0]] = 1'b1;
                idx                  = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/kdf_sched.sv
// kdf_sched: round-robin scheduler sharing one KDF_spongent core between
// NUM_REQ requesters. Latches the winner's inputs, releases the core reset,
// waits for end_signal (or a watchdog timeout) and reports with a pulse.
module kdf_sched
    import kdf_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int N              = KDF_N,
    parameter int SALT_WIDTH     = KDF_SALT_WIDTH,
    parameter int PSW_WIDTH      = KDF_PSW_WIDTH,
    parameter int COUNT_WIDTH    = KDF_COUNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*SALT_WIDTH-1:0]  salt_i,
    input  logic [NUM_REQ*PSW_WIDTH-1:0]   psw_i,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] count_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [N-1:0]                   key_o,
    output logic                           busy_o,
    output logic                           core_rst_o,
    output logic [SALT_WIDTH-1:0]          core_salt_o,
    output logic [PSW_WIDTH-1:0]           core_psw_o,
    output logic [COUNT_WIDTH-1:0]         core_count_o,
    input  logic                           core_end_i,
    input  logic [N-1:0]                   core_key_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // A disabled watchdog still needs a legal one-bit counter.
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    kdf_sched_state_t state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner_idx;
    logic [WD_W-1:0]  wd_cnt;
    logic [WD_W-1:0]  wd_inc;
    logic             timeout_hit;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic [SALT_WIDTH-1:0]  sel_salt;
    logic [PSW_WIDTH-1:0]   sel_psw;
    logic [COUNT_WIDTH-1:0] sel_count;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Mux the arbitration winner's operands out of the packed input buses.
    always_comb begin
        sel_salt  = '0;
        sel_psw   = '0;
        sel_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_salt  = salt_i[k*SALT_WIDTH +: SALT_WIDTH];
                sel_psw   = psw_i[k*PSW_WIDTH +: PSW_WIDTH];
                sel_count = count_i[k*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end
    end

    // The watchdog value including the current RUN cycle: first RUN cycle is 1.
    always_comb begin
        wd_inc      = wd_cnt + 1'b1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_inc == WD_LIMIT);
    end

    // Scheduler FSM with registered outputs, operand latches and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and key registers are reset too, so an aborted
            // job leaves nothing stale visible on the core or requester ports.
            state        <= IDLE;
            ptr          <= '0;
            owner_idx    <= '0;
            wd_cnt       <= '0;
            grant_o      <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            key_o        <= '0;
            core_rst_o   <= 1'b1;
            core_salt_o  <= '0;
            core_psw_o   <= '0;
            core_count_o <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    core_rst_o <= 1'b1;
                    done_o     <= 1'b0;
                    err_o      <= 1'b0;
                    if (|req_i) begin
                        core_salt_o  <= sel_salt;
                        core_psw_o   <= sel_psw;
                        core_count_o <= sel_count;
                        grant_o      <= arb_gnt;
                        owner_idx    <= arb_idx;
                        busy_o       <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    // Core stays in reset for one cycle with stable operands.
                    wd_cnt     <= '0;
                    core_rst_o <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    wd_cnt <= wd_inc;
                    if (core_end_i) begin
                        key_o      <= core_key_i;
                        done_o     <= 1'b1;
                        core_rst_o <= 1'b1;
                        state      <= DONE;
                    end else if (timeout_hit) begin
                        err_o      <= 1'b1;
                        core_rst_o <= 1'b1;
                        state      <= ERR;
                    end
                end
                DONE, ERR: begin
                    // Hand priority to the requester after the current owner.
                    ptr     <= (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
                    done_o  <= 1'b0;
                    err_o   <= 1'b0;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    core_rst_o <= 1'b1;
                    grant_o    <= '0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kdf_sched.sv
// tb_kdf_sched: directed bench for kdf_sched. dut_a uses the default watchdog,
// dut_b a 16-cycle watchdog; the bench plays the core by driving end/key.
module tb_kdf_sched;

    localparam int NR = 2;
    localparam int SW = 64;
    localparam int PW = 32;
    localparam int CW = 32;
    localparam int KW = 128;

    localparam logic [SW-1:0]  SALT0 = 64'h0123456789ABCDEF;
    localparam logic [SW-1:0]  SALT1 = 64'hFEDCBA9876543210;
    localparam logic [PW-1:0]  PSW0  = 32'hDEADBEEF;
    localparam logic [PW-1:0]  PSW1  = 32'hCAFEF00D;
    localparam logic [CW-1:0]  CNT0  = 32'd5;
    localparam logic [CW-1:0]  CNT1  = 32'd9;
    localparam logic [KW-1:0]  MASK  = 128'h5A5A_A5A5_3C3C_C3C3_0F0F_F0F0_1234_5678;

    logic clk = 1'b0;
    logic rst;
    logic [NR*SW-1:0] salt;
    logic [NR*PW-1:0] psw;
    logic [NR*CW-1:0] count;

    logic [NR-1:0] req_a, grant_a, req_b, grant_b;
    logic done_a, err_a, busy_a, core_rst_a, end_a;
    logic done_b, err_b, busy_b, core_rst_b, end_b;
    logic [KW-1:0] key_a, core_key_a, key_b, core_key_b;
    logic [SW-1:0] core_salt_a, core_salt_b;
    logic [PW-1:0] core_psw_a, core_psw_b;
    logic [CW-1:0] core_count_a, core_count_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kdf_sched #(.NUM_REQ(NR)) dut_a (
        .clk(clk), .rst(rst), .req_i(req_a), .salt_i(salt), .psw_i(psw),
        .count_i(count), .grant_o(grant_a), .done_o(done_a), .err_o(err_a),
        .key_o(key_a), .busy_o(busy_a), .core_rst_o(core_rst_a),
        .core_salt_o(core_salt_a), .core_psw_o(core_psw_a),
        .core_count_o(core_count_a), .core_end_i(end_a), .core_key_i(core_key_a)
    );

    kdf_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .req_i(req_b), .salt_i(salt), .psw_i(psw),
        .count_i(count), .grant_o(grant_b), .done_o(done_b), .err_o(err_b),
        .key_o(key_b), .busy_o(busy_b), .core_rst_o(core_rst_b),
        .core_salt_o(core_salt_b), .core_psw_o(core_psw_b),
        .core_count_o(core_count_b), .core_end_i(end_b), .core_key_i(core_key_b)
    );

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [KW-1:0] model_key(input int who);
        return (who == 0) ? ({SALT0, PSW0, CNT0} ^ MASK) : ({SALT1, PSW1, CNT1} ^ MASK);
    endfunction

    initial begin
        logic [KW-1:0] key_b_first;
        logic [NR-1:0] exp_gnt;
        int            who;

        rst = 1'b1; req_a = '0; req_b = '0; end_a = 1'b0; end_b = 1'b0;
        core_key_a = '0; core_key_b = '0;
        salt = {SALT1, SALT0}; psw = {PSW1, PSW0}; count = {CNT1, CNT0};
        step(2);

        // Reset values.
        check("rst_grant", grant_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_key", key_a, 0);
        check("rst_core_rst", core_rst_a, 1);
        check("rst_core_data", {core_salt_a, core_psw_a, core_count_a}, 0);
        check("rst_grant_b", grant_b, 0);
        rst = 1'b0;
        step(1);

        // Single request, core ends after 100 RUN cycles.
        req_a = 2'b01;
        step(1);
        check("single_grant", grant_a, 2'b01);
        check("single_busy", busy_a, 1);
        check("single_load_core_rst", core_rst_a, 1);
        check("single_core_data", {core_salt_a, core_psw_a, core_count_a}, {SALT0, PSW0, CNT0});
        step(1);
        check("single_run_core_rst", core_rst_a, 0);
        salt[0 +: SW] = 64'h1111_2222_3333_4444;
        step(1);
        check("latched_salt_run", core_salt_a, SALT0);
        step(98);
        end_a = 1'b1; core_key_a = model_key(0);
        step(1);
        end_a = 1'b0; req_a = '0;
        check("single_done", done_a, 1);
        check("single_no_err", err_a, 0);
        check("single_key", key_a, model_key(0));
        check("single_done_core_rst", core_rst_a, 1);
        step(1);
        check("single_idle_done", done_a, 0);
        check("single_idle_grant", grant_a, 0);
        check("single_idle_busy", busy_a, 0);
        check("latched_salt_idle", core_salt_a, SALT0);
        salt[0 +: SW] = SALT0;

        // Contention from pointer 0: grants alternate 01, 10, 01.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_a = 2'b11;
        step(1);
        for (int k = 0; k < 3; k++) begin
            who     = k % 2;
            exp_gnt = (who == 0) ? 2'b01 : 2'b10;
            check("cont_grant", grant_a, exp_gnt);
            check("cont_core_data", {core_salt_a, core_psw_a, core_count_a},
                  (who == 0) ? {SALT0, PSW0, CNT0} : {SALT1, PSW1, CNT1});
            step(1);
            check("cont_run_core_rst", core_rst_a, 0);
            step(4);
            end_a = 1'b1; core_key_a = model_key(who);
            step(1);
            end_a = 1'b0;
            if (k == 2) req_a = '0;
            check("cont_done", done_a, 1);
            check("cont_key", key_a, model_key(who));
            step(1);
            check("cont_idle_grant", grant_a, 0);
            step(1);
        end

        // Reset mid-RUN; afterwards requester 0 must win again (pointer 0).
        req_a = 2'b01;
        step(4);
        check("midrst_in_run", core_rst_a, 0);
        rst = 1'b1;
        step(1);
        check("midrst_grant", grant_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_core_rst", core_rst_a, 1);
        check("midrst_key", key_a, 0);
        check("midrst_pulses", {done_a, err_a}, 0);
        rst = 1'b0; req_a = 2'b11;
        step(1);
        check("midrst_ptr_grant", grant_a, 2'b01);
        step(1);
        end_a = 1'b1; core_key_a = model_key(0);
        step(1);
        end_a = 1'b0; req_a = '0;
        check("midrst_done", done_a, 1);
        step(1);

        // dut_b: a completed job by requester 1 leaves a key and pointer 0.
        req_b = 2'b10;
        step(1);
        check("to_pre_grant", grant_b, 2'b10);
        step(3);
        key_b_first = model_key(1);
        end_b = 1'b1; core_key_b = key_b_first;
        step(1);
        end_b = 1'b0; req_b = '0;
        check("to_pre_done", done_b, 1);
        step(1);

        // Timeout: core never ends, ERR 17 cycles after LOAD.
        req_b = 2'b01;
        step(1);
        check("to_grant", grant_b, 2'b01);
        step(16);
        check("to_run16_no_err", err_b, 0);
        check("to_run16_core_rst", core_rst_b, 0);
        step(1);
        check("to_err", err_b, 1);
        check("to_no_done", done_b, 0);
        check("to_core_rst", core_rst_b, 1);
        check("to_key_held", key_b, key_b_first);
        check("to_err_grant", grant_b, 2'b01);
        req_b = 2'b11;
        step(1);
        check("to_idle_err", err_b, 0);
        check("to_idle_busy", busy_b, 0);
        step(1);
        check("to_ptr_advanced", grant_b, 2'b10);

        // End in the RUN cycle where the watchdog reaches 16: end wins.
        step(16);
        end_b = 1'b1; core_key_b = key_b_first ^ 128'hFF;
        step(1);
        end_b = 1'b0; req_b = '0;
        check("coinc_done", done_b, 1);
        check("coinc_no_err", err_b, 0);
        check("coinc_key", key_b, key_b_first ^ 128'hFF);
        step(1);
        check("coinc_idle_err", err_b, 0);
        check("coinc_idle_busy", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
